// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and table-entry generator for the
// slice-by-4 CRC-32 engine (reflected IEEE 802.3 CRC).
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } crc32_state_e;

  // Entry of the standard byte table T0: eight reflected shift/xor steps.
  function automatic logic [31:0] crc32_t0_entry(input logic [7:0] idx);
    logic [31:0] e;
    e = {24'h000000, idx};
    for (int b = 0; b < 8; b++) begin
      e = e[0] ? ((e >> 1) ^ CRC32_POLY) : (e >> 1);
    end
    return e;
  endfunction

  // Entry of slice table Tk: Tk[i] = T0[Tk-1[i] & 0xFF] ^ (Tk-1[i] >> 8).
  function automatic logic [31:0] crc32_tab_entry(input int slice, input logic [7:0] idx);
    logic [31:0] e;
    e = crc32_t0_entry(idx);
    for (int k = 1; k < 4; k++) begin
      if (k <= slice) begin
        e = crc32_t0_entry(e[7:0]) ^ (e >> 8);
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/crc32_tab.sv
// One slice of the CRC-32 lookup table as a combinational 256-entry ROM.
// Contents are constant-folded from the package generator.
module crc32_tab
  import crc32_pkg::*;
#(
  parameter int SLICE = 0
) (
  input  logic [7:0]  addr_i,
  output logic [31:0] data_o
);

  logic [31:0] rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign rom[gi] = crc32_tab_entry(SLICE, 8'(gi));
  end

  // Unregistered read: the table sits inside the single-cycle CRC feedback loop.
  assign data_o = rom[addr_i];

endmodule

// File: rtl/crc32_slice4_engine.sv
// Streaming CRC-32 engine: folds one 32-bit word per clock through four
// table lookups, then finishes a 1..3 byte tail one byte per clock.
// Optional feature: define CRC32_PROTO_ERR_EN to add the saturating
// protocol-error counter port err_cnt.
module crc32_slice4_engine
  import crc32_pkg::*;
#(
  parameter int TAB_DEPTH_BITS = 8  // only 8 is meaningful
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_nbytes,
  output logic        out_valid,
  output logic [31:0] out_crc
`ifdef CRC32_PROTO_ERR_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  crc32_state_e state_q;
  logic [31:0]  crc_q;
  logic [23:0]  tail_q;
  logic [1:0]   tail_cnt_q;
  logic         out_valid_q;
  logic [31:0]  out_crc_q;

  logic [TAB_DEPTH_BITS-1:0] tab_addr [4];
  logic [31:0]               tab_data [4];

  logic        accept;
  logic        take_word;
  logic [31:0] crc_base;
  logic [31:0] x;
  logic [31:0] word_crc_d;
  logic [31:0] byte_crc_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_tab
    crc32_tab #(.SLICE(gi)) u_tab (
      .addr_i (tab_addr[gi]),
      .data_o (tab_data[gi])
    );
  end

  assign in_ready  = (state_q != ST_TAIL);
  assign accept    = in_valid && in_ready;
  // A word is folded in BODY always, and in IDLE only when it opens a frame.
  assign take_word = accept && (in_sop || (state_q == ST_BODY));

  // Table addressing: word step in IDLE/BODY, T0 borrowed for the byte step in TAIL.
  always_comb begin
    crc_base    = in_sop ? CRC32_INIT : crc_q;
    x           = crc_base ^ in_data;
    tab_addr[3] = x[7:0];
    tab_addr[2] = x[15:8];
    tab_addr[1] = x[23:16];
    tab_addr[0] = (state_q == ST_TAIL) ? (crc_q[7:0] ^ tail_q[7:0]) : x[31:24];
    word_crc_d  = tab_data[3] ^ tab_data[2] ^ tab_data[1] ^ tab_data[0];
    byte_crc_d  = tab_data[0] ^ {8'h00, crc_q[31:8]};
  end

  // Frame FSM with registered result and one-cycle result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC32_INIT;
      tail_q      <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_crc_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_BODY: begin
          if (take_word) begin
            if (in_eop && (in_nbytes == 2'd0)) begin
              out_crc_q   <= word_crc_d ^ CRC32_XOROUT;
              out_valid_q <= 1'b1;
              crc_q       <= CRC32_INIT;
              state_q     <= ST_IDLE;
            end else if (in_eop) begin
              crc_q      <= crc_base;
              tail_q     <= in_data[23:0];
              tail_cnt_q <= in_nbytes;
              state_q    <= ST_TAIL;
            end else begin
              crc_q   <= word_crc_d;
              state_q <= ST_BODY;
            end
          end
        end
        ST_TAIL: begin
          crc_q      <= byte_crc_d;
          tail_q     <= {8'h00, tail_q[23:8]};
          tail_cnt_q <= tail_cnt_q - 2'd1;
          if (tail_cnt_q == 2'd1) begin
            out_crc_q   <= byte_crc_d ^ CRC32_XOROUT;
            out_valid_q <= 1'b1;
            crc_q       <= CRC32_INIT;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;

`ifdef CRC32_PROTO_ERR_EN
  logic        proto_err;
  logic [15:0] err_cnt_q;

  assign proto_err = accept && (((state_q == ST_IDLE) && !in_sop) ||
                                ((state_q == ST_BODY) && in_sop));

  // Saturating count of dropped orphan words and mid-frame restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (proto_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_slice4_engine.sv
// Self-checking bench for crc32_slice4_engine: known-answer frame table,
// hand-written corner sequences and random frames against a bitwise CRC model.
module tb_crc32_slice4_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_nbytes;
  logic        out_valid;
  logic [31:0] out_crc;
`ifdef CRC32_PROTO_ERR_EN
  logic [15:0] err_cnt;
`endif

  crc32_slice4_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid),
    .out_crc   (out_crc)
`ifdef CRC32_PROTO_ERR_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [31:0] pulse_crc_q [$];
  int          pulse_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pulse_crc_q.push_back(out_crc);
      pulse_cyc_q.push_back(cyc);
      $display("[%0d] out_valid crc=%08h", cyc, out_crc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [7:0] q [$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulse_crc_q.delete();
    pulse_cyc_q.delete();
  endtask

  // Present one word at the first negedge where the engine is ready.
  task automatic drive_word(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] nb);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      in_valid = 1'b0;
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got in_ready=0 required 1");
    end
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_nbytes = nb;
    acc_cyc = cyc + 1;
    $display("[%0d] word %08h sop=%0b eop=%0b nb=%0d", acc_cyc, d, sop, eop, nb);
  endtask

  task automatic idle_input();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wait_pulse(input string name, output logic [31:0] crc, output int pc);
    int guard;
    guard = 0;
    crc = 32'hx; pc = -1;
    while (pulse_crc_q.size() == 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (pulse_crc_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_pulse_timeout: got no out_valid required a pulse", name);
    end else begin
      crc = pulse_crc_q.pop_front();
      pc  = pulse_cyc_q.pop_front();
    end
  endtask

  task automatic send_frame(input logic [7:0] q [$]);
    int n;
    int rem;
    logic [31:0] w;
    n = q.size();
    for (int i = 0; i < n; i += 4) begin
      rem = n - i;
      w = $urandom;
      for (int j = 0; j < 4 && j < rem; j++) w[8*j +: 8] = q[i+j];
      drive_word(w, i == 0, rem <= 4, (rem >= 4) ? 2'd0 : 2'(rem));
    end
  endtask

  typedef struct {
    string       name;
    int          nwords;
    logic [31:0] w [3];
    logic [1:0]  nb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] got;
  int          pc;
  int          pc_prev;
  int          lowc;
  logic [31:0] exp_q [$];
  logic [7:0]  bq [$];

  initial begin
    vecs[0] = '{"crc_123456789", 3, '{32'h34333231, 32'h38373635, 32'h00000039}, 2'd1, 32'hCBF43926};
    vecs[1] = '{"crc_1234",      1, '{32'h34333231, 32'h0, 32'h0},               2'd0, 32'h9BE3E0A3};
    vecs[2] = '{"crc_zero4",     1, '{32'h00000000, 32'h0, 32'h0},               2'd0, 32'h2144DF1C};
    vecs[3] = '{"crc_123",       1, '{32'h00333231, 32'h0, 32'h0},               2'd3, 32'h884863D2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_nbytes = '0;
    do_reset();

    // Reset state
    check32("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check32("rst_out_crc", out_crc, 32'h0);
    check32("rst_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef CRC32_PROTO_ERR_EN
    check32("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
`endif

    // Known-answer table: CRC value and result latency
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].nwords; i++) begin
        drive_word(vecs[v].w[i], i == 0, i == vecs[v].nwords - 1,
                   (i == vecs[v].nwords - 1) ? vecs[v].nb : 2'd0);
      end
      idle_input();
      wait_pulse(vecs[v].name, got, pc);
      check32(vecs[v].name, got, vecs[v].exp);
      check32({vecs[v].name, "_latency"}, 32'(pc - acc_cyc), 32'(vecs[v].nb));
    end

    // Back-to-back single-word zero frames: pulses on consecutive cycles
    for (int i = 0; i < 3; i++) drive_word(32'h0, 1'b1, 1'b1, 2'd0);
    idle_input();
    pc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_pulse("b2b", got, pc);
      check32("b2b_crc", got, 32'h2144DF1C);
      if (i > 0) check32("b2b_spacing", 32'(pc - pc_prev), 32'd1);
      pc_prev = pc;
    end

    // Three-byte tail: in_ready low exactly three cycles
    drive_word(32'h00333231, 1'b1, 1'b1, 2'd3);
    @(negedge clk);
    in_valid = 1'b0;
    lowc = 0;
    while (!in_ready && lowc < 10) begin
      lowc++;
      @(negedge clk);
    end
    check32("tail3_ready_low", 32'(lowc), 32'd3);
    wait_pulse("tail3", got, pc);
    check32("tail3_crc", got, 32'h884863D2);

    // Protocol errors: orphan word in IDLE, then sop mid-frame restart
    do_reset();
    drive_word(32'hDEADBEEF, 1'b0, 1'b1, 2'd0);
    drive_word(32'h11111111, 1'b1, 1'b0, 2'd0);
    drive_word(32'h34333231, 1'b1, 1'b1, 2'd0);
    idle_input();
    wait_pulse("proto", got, pc);
    check32("proto_crc", got, 32'h9BE3E0A3);
    repeat (5) @(negedge clk);
    check32("proto_extra_pulses", 32'(pulse_crc_q.size()), 32'd0);
`ifdef CRC32_PROTO_ERR_EN
    check32("proto_err_cnt", {16'h0, err_cnt}, 32'd2);
`endif

    // Reset during TAIL: frame discarded, engine idle, next frame fine
    drive_word(32'h00000031, 1'b1, 1'b1, 2'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check32("rst_tail_no_pulse", 32'(pulse_crc_q.size()), 32'd0);
    check32("rst_tail_ready", {31'h0, in_ready}, 32'h1);
    drive_word(32'h34333231, 1'b1, 1'b1, 2'd0);
    idle_input();
    wait_pulse("after_rst", got, pc);
    check32("after_rst_crc", got, 32'h9BE3E0A3);

    // Random frames against the bitwise reference model
    for (int f = 0; f < 30; f++) begin
      bq.delete();
      for (int i = 0; i < int'($urandom_range(1, 23)); i++) bq.push_back(8'($urandom));
      exp_q.push_back(crc_ref(bq));
      send_frame(bq);
      if ($urandom_range(0, 3) == 0) idle_input();
    end
    idle_input();
    for (int f = 0; f < 30; f++) begin
      wait_pulse("rand", got, pc);
      check32("rand_crc", got, exp_q.pop_front());
    end
    repeat (5) @(negedge clk);
    check32("rand_extra_pulses", 32'(pulse_crc_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
